// File: rtl/baopoco_adc_pwr_pkg.sv
//------------------------------------------------------------------------------
// Module  : baopoco_adc_pwr_pkg
// Brief   : Shared types and constants for the ADC power scheduler.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package baopoco_adc_pwr_pkg;

  // Scheduler states, explicitly 3 bits wide
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    ACC   = 3'd2,
    DRAIN = 3'd3,
    DUMP  = 3'd4
  } pwr_state_e;

  localparam int DRAIN_CYC = 2;   // cycles to empty the square/accumulate pipe
  localparam int DRN_W     = 2;   // width of the drain counter
  localparam int ACC_W     = 33;  // accumulator width, top bit flags overflow
  localparam int DCNT_W    = 24;  // completed-window counter width
  localparam int LEN_W     = 32;  // window length width

  // A zero window length behaves as a single-sample window
  function automatic logic [LEN_W-1:0] norm_len(input logic [LEN_W-1:0] len);
    return (len == '0) ? LEN_W'(1) : len;
  endfunction

endpackage

`default_nettype wire

// File: rtl/baopoco_adc_sq_acc.sv
//------------------------------------------------------------------------------
// Module  : baopoco_adc_sq_acc
// Brief   : Channel mux, registered squarer and 33-bit accumulator pipe.
//           Sample accepted at t, square registered at t+1, summed at t+2.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module baopoco_adc_sq_acc
  import baopoco_adc_pwr_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ADC_W  = 8,
  parameter int CH_W   = 2
) (
  input  logic                    user_clk,
  input  logic                    user_rst,
  input  logic [NUM_CH*ADC_W-1:0] adc_data,
  input  logic [CH_W-1:0]         sel,
  input  logic                    valid,
  input  logic                    clr,
  output logic [ACC_W-1:0]        acc,
  output logic                    ovf
);

  // Square of the most negative sample needs 2*ADC_W-1 bits, no sign
  localparam int SQ_W = 2 * ADC_W - 1;

  logic [ADC_W-1:0]          ch_samp [NUM_CH];
  logic signed [ADC_W-1:0]   sample;
  logic signed [2*ADC_W-1:0] prod;

  logic [SQ_W-1:0]  sq_d, sq_q;
  logic             sq_vld_d, sq_vld_q;
  logic [ACC_W-1:0] acc_d, acc_q;
  logic             ovf_d, ovf_q;

  // Unpack the flat sample bus into per-channel words
  for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
    assign ch_samp[k] = adc_data[k*ADC_W +: ADC_W];
  end

  // Square the selected sample; accumulate last cycle's square; clr drops
  // anything in flight so an aborted window cannot leak into the next one
  always_comb begin
    sample   = signed'(ch_samp[sel]);
    prod     = sample * sample;
    sq_d     = prod[SQ_W-1:0];
    sq_vld_d = valid & ~clr;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    if (clr) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (sq_vld_q) begin
      acc_d = acc_q + {{(ACC_W-SQ_W){1'b0}}, sq_q};
      ovf_d = ovf_q | acc_d[ACC_W-1];
    end
  end

  // Pipe registers
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      sq_q     <= '0;
      sq_vld_q <= 1'b0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      sq_q     <= sq_d;
      sq_vld_q <= sq_vld_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
    end
  end

  assign acc = acc_q;
  assign ovf = ovf_q;

endmodule

`default_nettype wire

// File: rtl/baopoco_adc_pwr_sched.sv
//------------------------------------------------------------------------------
// Module  : baopoco_adc_pwr_sched
// Brief   : Round-robin ADC power (sum-of-squares) scheduler for software
//           readout. Optional macro BAOPOCO_ADC_PWR_SAT_EN saturates sum_sq
//           to all-ones on an overflowed window instead of wrapping.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module baopoco_adc_pwr_sched
  import baopoco_adc_pwr_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int ADC_W  = 8,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic                    user_clk,
  input  logic                    user_rst,
  input  logic [NUM_CH*ADC_W-1:0] adc_data,
  input  logic                    adc_valid,
  input  logic                    sync_in,
  input  logic                    ctrl_en,
  input  logic [LEN_W-1:0]        acc_len,
  output logic [31:0]             sum_sq,
  output logic [CH_W-1:0]         sum_ch,
  output logic [DCNT_W-1:0]       dump_cnt,
  output logic                    dump_stb,
  output logic                    busy,
  output logic                    ovf
);

  pwr_state_e state_d, state_q;
  logic [CH_W-1:0]   ch_d, ch_q;
  logic [LEN_W-1:0]  len_d, len_q;
  logic [LEN_W-1:0]  cnt_d, cnt_q;
  logic [LEN_W-1:0]  cnt_inc;
  logic [DRN_W-1:0]  drain_d, drain_q;
  logic [31:0]       sum_sq_d, sum_sq_q;
  logic [CH_W-1:0]   sum_ch_d, sum_ch_q;
  logic [DCNT_W-1:0] dump_cnt_d, dump_cnt_q;
  logic              dump_stb_d, dump_stb_q;
  logic              ovf_d, ovf_q;

  logic              pipe_vld;
  logic              pipe_clr;
  logic              restart;
  logic [ACC_W-1:0]  acc_val;
  logic              acc_ovf;
  logic              win_ovf;

  baopoco_adc_sq_acc #(
    .NUM_CH (NUM_CH),
    .ADC_W  (ADC_W),
    .CH_W   (CH_W)
  ) u_sq_acc (
    .user_clk (user_clk),
    .user_rst (user_rst),
    .adc_data (adc_data),
    .sel      (ch_q),
    .valid    (pipe_vld),
    .clr      (pipe_clr),
    .acc      (acc_val),
    .ovf      (acc_ovf)
  );

  // Sticky flag plus the live carry bit, so a carry on the final add counts
  assign win_ovf = acc_ovf | acc_val[ACC_W-1];
  assign cnt_inc = cnt_q + LEN_W'(1);

  // Next-state and datapath control; abort beats sync, sync beats samples
  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    drain_d    = drain_q;
    sum_sq_d   = sum_sq_q;
    sum_ch_d   = sum_ch_q;
    dump_cnt_d = dump_cnt_q;
    dump_stb_d = 1'b0;
    ovf_d      = ovf_q;
    pipe_vld   = 1'b0;
    pipe_clr   = 1'b0;
    restart    = 1'b0;

    case (state_q)
      IDLE: begin
        if (ctrl_en) state_d = ARM;
      end
      ARM: begin
        if (!ctrl_en)     state_d = IDLE;
        else if (sync_in) restart = 1'b1;
      end
      ACC: begin
        if (!ctrl_en) begin
          state_d = IDLE;
        end else if (sync_in) begin
          restart = 1'b1;
        end else if (adc_valid) begin
          pipe_vld = 1'b1;
          cnt_d    = cnt_inc;
          if (cnt_inc >= len_q) begin
            state_d = DRAIN;
            drain_d = '0;
          end
        end
      end
      DRAIN: begin
        if (!ctrl_en) begin
          state_d = IDLE;
        end else if (sync_in) begin
          restart = 1'b1;
        end else if (drain_q == DRN_W'(DRAIN_CYC - 1)) begin
          state_d = DUMP;
        end else begin
          drain_d = drain_q + DRN_W'(1);
        end
      end
      DUMP: begin
`ifdef BAOPOCO_ADC_PWR_SAT_EN
        sum_sq_d = win_ovf ? 32'hFFFF_FFFF : acc_val[31:0];
`else
        sum_sq_d = acc_val[31:0];
`endif
        sum_ch_d   = ch_q;
        ovf_d      = win_ovf;
        dump_stb_d = 1'b1;
        dump_cnt_d = dump_cnt_q + DCNT_W'(1);
        ch_d       = ch_q + CH_W'(1);
        len_d      = norm_len(acc_len);
        cnt_d      = '0;
        pipe_clr   = 1'b1;
        state_d    = ctrl_en ? ACC : IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Fresh window aligned to sync: channel 0, new length, empty pipe
    if (restart) begin
      state_d  = ACC;
      ch_d     = '0;
      len_d    = norm_len(acc_len);
      cnt_d    = '0;
      pipe_clr = 1'b1;
    end
  end

  // State, counters and software-visible result registers
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      len_q      <= LEN_W'(1);
      cnt_q      <= '0;
      drain_q    <= '0;
      sum_sq_q   <= '0;
      sum_ch_q   <= '0;
      dump_cnt_q <= '0;
      dump_stb_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      drain_q    <= drain_d;
      sum_sq_q   <= sum_sq_d;
      sum_ch_q   <= sum_ch_d;
      dump_cnt_q <= dump_cnt_d;
      dump_stb_q <= dump_stb_d;
      ovf_q      <= ovf_d;
    end
  end

  assign sum_sq   = sum_sq_q;
  assign sum_ch   = sum_ch_q;
  assign dump_cnt = dump_cnt_q;
  assign dump_stb = dump_stb_q;
  assign ovf      = ovf_q;
  assign busy     = (state_q == ARM) || (state_q == ACC) || (state_q == DRAIN);

endmodule

`default_nettype wire

// File: tb/tb_baopoco_adc_pwr_sched.sv
//------------------------------------------------------------------------------
// Module  : tb_baopoco_adc_pwr_sched
// Brief   : Directed self-checking bench for baopoco_adc_pwr_sched.
//           A second instance with 12-bit samples reaches overflow quickly.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_baopoco_adc_pwr_sched;

  logic        clk;
  logic        rst;

  // Main instance: 4 channels, 8-bit samples
  logic [31:0] adc_data;
  logic        adc_valid, sync_in, ctrl_en;
  logic [31:0] acc_len;
  logic [31:0] sum_sq;
  logic [1:0]  sum_ch;
  logic [23:0] dump_cnt;
  logic        dump_stb, busy, ovf;

  // Overflow instance: 4 channels, 12-bit samples
  logic [47:0] adc_data2;
  logic        adc_valid2, sync_in2, ctrl_en2;
  logic [31:0] acc_len2;
  logic [31:0] sum_sq2;
  logic [1:0]  sum_ch2;
  logic [23:0] dump_cnt2;
  logic        dump_stb2, busy2, ovf2;

  int checks   = 0;
  int failures = 0;
  int n;

  baopoco_adc_pwr_sched #(.NUM_CH(4), .ADC_W(8)) dut (
    .user_clk (clk),      .user_rst (rst),
    .adc_data (adc_data), .adc_valid(adc_valid),
    .sync_in  (sync_in),  .ctrl_en  (ctrl_en),
    .acc_len  (acc_len),  .sum_sq   (sum_sq),
    .sum_ch   (sum_ch),   .dump_cnt (dump_cnt),
    .dump_stb (dump_stb), .busy     (busy),
    .ovf      (ovf)
  );

  baopoco_adc_pwr_sched #(.NUM_CH(4), .ADC_W(12)) dut2 (
    .user_clk (clk),       .user_rst (rst),
    .adc_data (adc_data2), .adc_valid(adc_valid2),
    .sync_in  (sync_in2),  .ctrl_en  (ctrl_en2),
    .acc_len  (acc_len2),  .sum_sq   (sum_sq2),
    .sum_ch   (sum_ch2),   .dump_cnt (dump_cnt2),
    .dump_stb (dump_stb2), .busy     (busy2),
    .ovf      (ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Step until the main instance strobes, bounded
  task automatic wait_dump(input int limit, output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!dump_stb && cyc < limit);
    chk("dump_stb_seen", dump_stb, 1);
  endtask

  task automatic wait_dump2(input int limit, output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!dump_stb2 && cyc < limit);
    chk("dump_stb2_seen", dump_stb2, 1);
  endtask

  // IDLE -> ARM -> ACC via one sync pulse
  task automatic start_window();
    ctrl_en = 1'b1;
    step();
    sync_in = 1'b1;
    step();
    sync_in = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    adc_data = '0; adc_valid = 0; sync_in = 0; ctrl_en = 0; acc_len = 0;
    adc_data2 = '0; adc_valid2 = 0; sync_in2 = 0; ctrl_en2 = 0; acc_len2 = 0;
    repeat (3) step();

    // Reset values
    chk("rst_sum_sq", sum_sq, 0);
    chk("rst_sum_ch", sum_ch, 0);
    chk("rst_dump_cnt", dump_cnt, 0);
    chk("rst_dump_stb", dump_stb, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;
    step();

    // Single window: ch0=3, acc_len=4 -> 36
    adc_data = {8'd7, 8'd7, 8'd7, 8'd3};
    adc_valid = 1'b1;
    acc_len = 4;
    ctrl_en = 1'b1;
    step();
    chk("arm_busy", busy, 1);
    sync_in = 1'b1;
    step();
    sync_in = 1'b0;
    wait_dump(50, n);
    chk("t1_latency", n, 7);
    chk("t1_sum_sq", sum_sq, 36);
    chk("t1_sum_ch", sum_ch, 0);
    chk("t1_dump_cnt", dump_cnt, 1);
    chk("t1_ovf", ovf, 0);
    step();
    chk("t1_stb_pulse", dump_stb, 0);
    ctrl_en = 1'b0;
    step();
    chk("t1_abort_busy", busy, 0);
    chk("t1_hold_sum", sum_sq, 36);

    // Continuous round-robin: ch k = k+1, acc_len=2
    adc_data = {8'd4, 8'd3, 8'd2, 8'd1};
    acc_len = 2;
    start_window();
    for (int w = 0; w < 5; w++) begin
      wait_dump(50, n);
      chk("rr_sum_sq", sum_sq, 2 * ((w % 4) + 1) * ((w % 4) + 1));
      chk("rr_sum_ch", sum_ch, w % 4);
      chk("rr_dump_cnt", dump_cnt, w + 2);
    end
    ctrl_en = 1'b0;
    step(); step();

    // Sync at sample 3 of 4 discards the partial window
    adc_data = {8'd0, 8'd0, 8'd0, 8'd5};
    acc_len = 4;
    start_window();
    step(); step();
    sync_in = 1'b1;
    step();
    sync_in = 1'b0;
    chk("resync_no_stb", dump_stb, 0);
    chk("resync_busy", busy, 1);
    wait_dump(50, n);
    chk("resync_latency", n, 7);
    chk("resync_sum_sq", sum_sq, 100);
    chk("resync_sum_ch", sum_ch, 0);
    chk("resync_dump_cnt", dump_cnt, 7);
    ctrl_en = 1'b0;
    step(); step();

    // acc_len=0 -> one-sample windows; valid gaps stretch them
    adc_data = {8'd0, 8'd0, 8'hFD, 8'd2};
    acc_len = 0;
    adc_valid = 1'b0;
    start_window();
    step(); step(); step();
    chk("len0_gap_busy", busy, 1);
    chk("len0_gap_cnt", dump_cnt, 7);
    adc_valid = 1'b1;
    step();
    adc_valid = 1'b0;
    wait_dump(50, n);
    chk("len0_latency", n, 3);
    chk("len0_sum_a", sum_sq, 4);
    chk("len0_ch_a", sum_ch, 0);
    step(); step();
    adc_valid = 1'b1;
    step();
    adc_valid = 1'b0;
    wait_dump(50, n);
    chk("len0_sum_neg", sum_sq, 9);
    chk("len0_ch_b", sum_ch, 1);
    chk("len0_dump_cnt", dump_cnt, 9);
    ctrl_en = 1'b0;
    step();

    // ctrl_en drop mid-ACC: back to IDLE, outputs hold, no dump
    adc_data = {8'd0, 8'd0, 8'd0, 8'd3};
    acc_len = 4;
    adc_valid = 1'b1;
    start_window();
    step(); step();
    ctrl_en = 1'b0;
    step();
    chk("abort_busy", busy, 0);
    chk("abort_sum_sq", sum_sq, 9);
    chk("abort_sum_ch", sum_ch, 1);
    repeat (10) step();
    chk("abort_dump_cnt", dump_cnt, 9);
    chk("abort_stb", dump_stb, 0);
    start_window();
    wait_dump(50, n);
    chk("reen_latency", n, 7);
    chk("reen_sum_sq", sum_sq, 36);
    chk("reen_sum_ch", sum_ch, 0);
    chk("reen_dump_cnt", dump_cnt, 10);

    // Asynchronous reset mid-window clears outputs at once
    step(); step();
    #2 rst = 1'b1;
    #1;
    chk("arst_sum_sq", sum_sq, 0);
    chk("arst_dump_cnt", dump_cnt, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ovf", ovf, 0);
    ctrl_en = 1'b0;
    adc_valid = 1'b0;
    step();
    rst = 1'b0;
    step();

    // Overflow: 12-bit -2048 squared is 2^22; 1023 fit, 1024 reach 2^32
    adc_data2 = {4{12'h800}};
    adc_valid2 = 1'b1;
    acc_len2 = 1023;
    ctrl_en2 = 1'b1;
    step();
    sync_in2 = 1'b1;
    step();
    sync_in2 = 1'b0;
    acc_len2 = 1024;
    wait_dump2(1100, n);
    chk("nofl_latency", n, 1026);
    chk("nofl_sum_sq", sum_sq2, 32'hFFC0_0000);
    chk("nofl_ovf", ovf2, 0);
    chk("nofl_sum_ch", sum_ch2, 0);
    wait_dump2(1100, n);
`ifdef BAOPOCO_ADC_PWR_SAT_EN
    chk("ofl_sum_sq", sum_sq2, 32'hFFFF_FFFF);
`else
    chk("ofl_sum_sq", sum_sq2, 32'h0000_0000);
`endif
    chk("ofl_ovf", ovf2, 1);
    chk("ofl_sum_ch", sum_ch2, 1);
    chk("ofl_dump_cnt", dump_cnt2, 2);
    ctrl_en2 = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
